// File: rtl/xdff_bank_arb.sv
// Round-robin arbiter that turns one granted command into a single-cycle
// enable/set/reset pulse on a W-bit flip-flop bank, then handshakes the winner.
//
// state  | meaning
// IDLE   | sample req0/req1, grant and register the winner's bank controls
// ISSUE  | bank control pulse is on the outputs for exactly one cycle
// ACK    | winner's ack held high until its req drops
module xdff_bank_arb #(
    parameter int W = 4
) (
    input  logic         clk0,
    input  logic         Rs,
    input  logic         req0,
    input  logic         req1,
    input  logic [1:0]   op0,
    input  logic [1:0]   op1,
    input  logic [W-1:0] data0,
    input  logic [W-1:0] data1,
    output logic         ack0,
    output logic         ack1,
    output logic         bank_en,
    output logic [W-1:0] bank_d,
    output logic         bank_s,
    output logic         bank_rs,
    output logic         busy,
    output logic         last_gnt
);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_ACK   = 2'b10
    } state_t;

    state_t         state, state_nx;
    logic           win, win_nx;
    logic           last_gnt_nx;
    logic           ack0_nx, ack1_nx;
    logic           bank_en_nx, bank_s_nx, bank_rs_nx;
    logic [W-1:0]   bank_d_nx;
    logic           busy_nx;

    logic           gnt_sel;
    logic [1:0]     op_sel;
    logic [W-1:0]   data_sel;
    logic           win_req;

    // A tie goes to the requester that was not served last.
    assign gnt_sel  = (req0 && req1) ? ~last_gnt : req1;
    assign op_sel   = gnt_sel ? op1 : op0;
    assign data_sel = gnt_sel ? data1 : data0;
    assign win_req  = win ? req1 : req0;

    always_comb begin
        state_nx    = state;
        win_nx      = win;
        last_gnt_nx = last_gnt;
        ack0_nx     = 1'b0;
        ack1_nx     = 1'b0;
        bank_en_nx  = 1'b0;
        bank_s_nx   = 1'b0;
        bank_rs_nx  = 1'b0;
        bank_d_nx   = '0;
        busy_nx     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_nx    = ST_ISSUE;
                    win_nx      = gnt_sel;
                    last_gnt_nx = gnt_sel;
                    busy_nx     = 1'b1;
                    // The registered controls are the latched command.
                    case (op_sel)
                        OP_LOAD: begin
                            bank_en_nx = 1'b1;
                            bank_d_nx  = data_sel;
                        end
                        OP_SET:   bank_s_nx  = 1'b1;
                        OP_CLEAR: bank_rs_nx = 1'b1;
                        OP_NOP:   ;
                        default:  ;
                    endcase
                end
            end

            ST_ISSUE: begin
                state_nx = ST_ACK;
                busy_nx  = 1'b1;
                ack0_nx  = ~win;
                ack1_nx  = win;
            end

            ST_ACK: begin
                if (!win_req) begin
                    state_nx = ST_IDLE;
                end else begin
                    busy_nx = 1'b1;
                    ack0_nx = ~win;
                    ack1_nx = win;
                end
            end

            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (Rs) begin
            state    <= ST_IDLE;
            win      <= 1'b0;
            last_gnt <= 1'b1;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            bank_en  <= 1'b0;
            bank_s   <= 1'b0;
            bank_rs  <= 1'b0;
            bank_d   <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            win      <= win_nx;
            last_gnt <= last_gnt_nx;
            ack0     <= ack0_nx;
            ack1     <= ack1_nx;
            bank_en  <= bank_en_nx;
            bank_s   <= bank_s_nx;
            bank_rs  <= bank_rs_nx;
            bank_d   <= bank_d_nx;
            busy     <= busy_nx;
        end
    end

    a_ack_excl : assert property (@(posedge clk0) disable iff (Rs) !(ack0 && ack1));
    a_ctrl_one : assert property (@(posedge clk0) disable iff (Rs)
                                  $onehot0({bank_en, bank_s, bank_rs}));

endmodule
